// File: rtl/mem_port_arb.sv
// Two-requester arbiter for a shared Avalon-style memory port.
// m0 (load/store) normally wins; m1 (fetch) is forced through after MAX_CONSEC m0 wins.
module mem_port_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_CONSEC = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  m0_rd,
  input  logic                  m0_wr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wr_data,
  input  logic [BE_WIDTH-1:0]   m0_wr_be,
  output logic [DATA_WIDTH-1:0] m0_rd_data,
  output logic                  m0_waitrequest,
  input  logic                  m1_rd,
  input  logic                  m1_wr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wr_data,
  input  logic [BE_WIDTH-1:0]   m1_wr_be,
  output logic [DATA_WIDTH-1:0] m1_rd_data,
  output logic                  m1_waitrequest,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [BE_WIDTH-1:0]   mem_wr_be,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_waitrequest,
  output logic [1:0]            grant,
  output logic                  busy
);

  localparam logic [3:0] MAX_C = 4'(MAX_CONSEC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] consec, consec_nxt;
  logic       m0_req, m1_req;

  assign m0_req = m0_rd | m0_wr;
  assign m1_req = m1_rd | m1_wr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      consec <= 4'd0;
    end else begin
      state  <= state_nxt;
      consec <= consec_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    consec_nxt     = consec;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = m0_addr;
    mem_wr_data    = m0_wr_data;
    mem_wr_be      = m0_wr_be;
    m0_waitrequest = m0_req;
    m1_waitrequest = m1_req;
    grant          = 2'b00;
    case (state)
      IDLE: begin
        // m0 wins unless m1 has been passed over MAX_CONSEC times in a row
        if (m0_req && !(m1_req && consec >= MAX_C)) begin
          state_nxt = OWN0;
          if (m1_req && consec < MAX_C) consec_nxt = consec + 4'd1;
        end else if (m1_req) begin
          state_nxt  = OWN1;
          consec_nxt = 4'd0;
        end
      end
      OWN0: begin
        grant          = 2'b01;
        mem_rd         = m0_rd;
        mem_wr         = m0_wr;
        m0_waitrequest = mem_waitrequest;
        if (!m0_req || !mem_waitrequest) state_nxt = IDLE;
      end
      OWN1: begin
        grant          = 2'b10;
        mem_rd         = m1_rd;
        mem_wr         = m1_wr;
        mem_addr       = m1_addr;
        mem_wr_data    = m1_wr_data;
        mem_wr_be      = m1_wr_be;
        m1_waitrequest = mem_waitrequest;
        if (!m1_req || !mem_waitrequest) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = |grant;
  assign m0_rd_data = mem_rd_data;
  assign m1_rd_data = mem_rd_data;

endmodule
